oh_stream_demux9: RTL
=====================

// Module: oh_stream_demux9
// PURPOSE
//  1:9 one-hot stream demultiplexer. The inverse of the 9:1 one-hot mux.
//  Routes one valid/ready input stream to one of nine output lanes, chosen by a one-hot select.
//  Each lane has a one-entry output register, so every lane output is registered.
//  Sits between a single producer and nine consumers, for example a packet dispatcher feeding per-port queues.
// PARAMETERS
//  N   32  data width of the input stream and of each output lane
// PORTS
//  clk        in   1    clock; all logic is on the rising edge
//  nreset     in   1    asynchronous, active-low reset
//  in_valid   in   1    input word valid
//  in_sel     in   9    one-hot lane select; bit i selects lane i
//  in_data    in   N    input word
//  in_ready   out  1    input accepted when in_valid & in_ready
//  out_valid  out  9    per-lane valid
//  out_data   out  9*N  lane i data is out_data[i*N +: N]
//  out_ready  in   9    per-lane downstream ready
//  err        out  1    one-cycle pulse when an illegal select is consumed
//  err_cnt    out  8    saturating count of illegal selects
// BEHAVIOUR
//  Reset (nreset low, async): out_valid=0, out_data=0, err=0, err_cnt=0.
//   - Outputs are held at these values while nreset stays low.
//   - An in-flight word is discarded; there is no partial state after release.
//  Legal select means in_sel has exactly one bit set.
//  Lane i register is free when ~out_valid[i] | out_ready[i].
//  in_ready is combinational:
//   - legal select: in_ready = free(selected lane).
//   - illegal select: in_ready = 1.
//   - There is a combinational path from out_ready to in_ready. This is intended.
//  Accept (legal, in_valid & in_ready), at the clock edge:
//   - out_data[lane] <= in_data and out_valid[lane] <= 1.
//   - Latency is 1 cycle from accept to out_valid.
//  Lane drain: out_valid[i] & out_ready[i] with no new accept to lane i.
//   - out_valid[i] <= 0.
//   - out_data[i] holds its value. It is don't-care once invalid.
//  Simultaneous drain and accept on the same lane: the new word replaces the old one.
//   - out_valid stays 1.
//   - Full throughput of one word per cycle per lane, with no bubbles.
//  Stall: while out_valid[i] & ~out_ready[i], out_data[i] is stable.
//  Lanes are independent. Draining any lane never affects another lane.
//  Illegal select (zero bits or more than one bit set) with in_valid:
//   - The word is consumed and dropped; no lane is written.
//   - err=1 for the next cycle only.
//   - err_cnt increments by 1 and saturates at 255; no wrap-around.
//  in_valid=0: no state change. in_sel and in_data are ignored.
//  No FSM beyond the per-lane valid bits, which act as 9 independent EMPTY/FULL states:
//   - EMPTY -> FULL on accept.
//   - FULL -> EMPTY on drain without accept.
//   - FULL -> FULL on stall, or on drain with a simultaneous accept.
// TESTING
//  1. Assert nreset low mid-traffic with lane 3 full and stalled
//     -> out_valid=0, out_data=0 and err_cnt=0 immediately, without waiting for clk.
//  2. in_sel=9'h004, in_data=32'hA5A5A5A5, out_ready=9'h1FF
//     -> next cycle out_valid=9'h004 and lane 2 data=32'hA5A5A5A5; the cycle after, out_valid=0.
//  3. Lane 5 with out_ready[5]=0; send 32'h1 then 32'h2
//     -> first word held, in_ready=0 for the second word.
//     -> raise out_ready[5]: the second word is accepted in that cycle, and lane 5 shows 32'h2 the next cycle.
//  4. in_sel=9'h000, then 9'h011, each with in_valid
//     -> in_ready=1 both times, err pulses twice, err_cnt=2, out_valid stays 0.
//  5. 300 consecutive illegal selects
//     -> err_cnt=255 and holds there; err remains 1 every cycle.
//  6. Back-to-back stream alternating lanes 0 and 8, all out_ready=1, 100 words
//     -> one accept per cycle, in_ready always 1, output data order matches input order per lane.

Source files
------------

// File: rtl/oh_stream_demux9.sv
// oh_stream_demux9: 1:9 one-hot valid/ready stream demultiplexer.
// Each lane owns a one-entry output register. An illegal select consumes and
// drops the word, pulses err and bumps a saturating error counter.
module oh_stream_demux9 #(
    parameter int N = 32
) (
    input  logic           clk,
    input  logic           nreset,
    input  logic           in_valid,
    input  logic [8:0]     in_sel,
    input  logic [N-1:0]   in_data,
    output logic           in_ready,
    output logic [8:0]     out_valid,
    output logic [9*N-1:0] out_data,
    input  logic [8:0]     out_ready,
    output logic           err,
    output logic [7:0]     err_cnt
);

    logic [8:0]     valid_q, valid_d;
    logic [9*N-1:0] data_q, data_d;
    logic           err_q, err_d;
    logic [7:0]     cnt_q, cnt_d;

    logic           legal;
    logic [8:0]     lane_free;
    logic [8:0]     accept;

    // Select legality, per-lane free status and the combinational ready
    always_comb begin
        legal     = (in_sel != '0) && ((in_sel & (in_sel - 9'd1)) == '0);
        lane_free = ~valid_q | out_ready;
        in_ready  = legal ? |(lane_free & in_sel) : 1'b1;
        accept    = (in_valid && in_ready && legal) ? in_sel : '0;
    end

    // Per-lane next state: accept loads (and wins over drain), drain clears valid
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        for (int unsigned i = 0; i < 9; i++) begin
            if (accept[i]) begin
                valid_d[i]        = 1'b1;
                data_d[i*N +: N]  = in_data;
            end else if (valid_q[i] && out_ready[i]) begin
                valid_d[i]        = 1'b0;
            end
        end
    end

    // Error pulse and saturating error count for consumed illegal selects
    always_comb begin
        err_d = in_valid && !legal;
        cnt_d = cnt_q;
        if (err_d && (cnt_q != '1)) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            valid_q <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign err       = err_q;
    assign err_cnt   = cnt_q;

endmodule
